// File: rtl/kmeans_k2n2_centroid_update.sv
// -----------------------------------------------------------------------------
// kmeans_k2n2_centroid_update
//
// Centroid-update stage of a k=2, n=2 k-means datapath. Classified points are
// accumulated into per-cluster sums and counts. After the last point of a
// pass, a single shared restoring divider computes the four means one after
// another (k0_d0, k0_d1, k1_d0, k1_d1). The new centroids are then committed
// in one cycle, and done pulses for that cycle.
//
// Optional feature macro: KMEANS_ROUND_EN
//   undefined : truncating mean, SW divider cycles per operand
//   defined   : round-half-up mean (sum + count/2), SW+1 cycles per operand,
//               result clamped to 2^data_width-1
//
// Ports:
//   clk                        rising-edge clock
//   rst                        asynchronous active-low reset
//   start                      pulse: clear accumulators and err (ACCUM only)
//   in_valid / in_ready        point handshake (in_ready high only in ACCUM)
//   in_d0, in_d1               point coordinates
//   in_cluster                 assigned cluster (0 or 1)
//   in_last                    final point of the pass
//   k0_d0..k1_d1               current centroids (registered)
//   done                       one-cycle pulse when centroids are committed
//   converged                  new centroids equal previous; held until next done
//   err                        sticky: point dropped because the pass was full
// -----------------------------------------------------------------------------
module kmeans_k2n2_centroid_update #(
  parameter int data_width               = 8,
  parameter int input_data_qty_bit_width = 8,
  parameter int input_data_qty           = 256,
  parameter int k0_d0_initial            = 0,
  parameter int k0_d1_initial            = 0,
  parameter int k1_d0_initial            = 1,
  parameter int k1_d1_initial            = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [data_width-1:0] in_d0,
  input  logic [data_width-1:0] in_d1,
  input  logic                  in_cluster,
  input  logic                  in_last,
  output logic [data_width-1:0] k0_d0,
  output logic [data_width-1:0] k0_d1,
  output logic [data_width-1:0] k1_d0,
  output logic [data_width-1:0] k1_d1,
  output logic                  done,
  output logic                  converged,
  output logic                  err
);

  localparam int SW = data_width + input_data_qty_bit_width;
  localparam int CW = input_data_qty_bit_width + 1;
`ifdef KMEANS_ROUND_EN
  localparam int DVW = SW + 1;
`else
  localparam int DVW = SW;
`endif
  localparam int BCW = $clog2(DVW);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DVW - 1);
  localparam logic [CW:0]    QTY      = (CW+1)'(input_data_qty);
  localparam logic [DVW-1:0] MAX_MEAN = DVW'((2 ** data_width) - 1);

  localparam logic [1:0] ACCUM  = 2'd0;
  localparam logic [1:0] DIV    = 2'd1;
  localparam logic [1:0] COMMIT = 2'd2;

  // Converts a raw quotient into a centroid component; an empty cluster
  // keeps its previous position instead of using the divide-by-zero result.
  function automatic logic [data_width-1:0] f_to_centroid(
    input logic [DVW-1:0]        quot,
    input logic [CW-1:0]         cnt,
    input logic [data_width-1:0] old
  );
    logic [data_width-1:0] res;
    if (cnt == '0) begin
      res = old;
    end else if (quot > MAX_MEAN) begin
      res = '1;
    end else begin
      res = quot[data_width-1:0];
    end
    return res;
  endfunction

  logic [1:0]            r_state;
  logic [1:0]            w_next_state;
  logic                  r_in_ready;
  logic [SW-1:0]         r_sum0_d0, r_sum0_d1, r_sum1_d0, r_sum1_d1;
  logic [CW-1:0]         r_cnt0, r_cnt1;
  logic                  r_err;
  logic [BCW-1:0]        r_bit_cnt;
  logic [1:0]            r_op_idx;
  logic [CW-1:0]         r_rem;
  logic [DVW-2:0]        r_quot;
  logic [data_width-1:0] r_res0, r_res1, r_res2;
  logic [data_width-1:0] r_k0_d0, r_k0_d1, r_k1_d0, r_k1_d1;
  logic                  r_done, r_converged;

  logic [CW:0]           w_total;
  logic                  w_full, w_accept, w_take, w_drop;
  logic                  w_div_last_bit, w_div_done;
  logic [SW-1:0]         w_sum_sel;
  logic [CW-1:0]         w_cnt_sel;
  logic [data_width-1:0] w_old_sel;
  logic [DVW-1:0]        w_dividend;
  logic                  w_dvd_bit;
  logic [CW:0]           w_rem_shift;
  logic                  w_qbit;
  logic [CW-1:0]         w_rem_next;
  logic [DVW-1:0]        w_quot_next;
  logic [data_width-1:0] w_res_cur;

  // Handshake qualification: start always wins over a same-cycle point.
  always_comb begin
    w_total        = {1'b0, r_cnt0} + {1'b0, r_cnt1};
    w_full         = (w_total >= QTY);
    w_accept       = (r_state == ACCUM) && in_valid;
    w_take         = w_accept && !start && !w_full;
    w_drop         = w_accept && !start && w_full;
    w_div_last_bit = (r_state == DIV) && (r_bit_cnt == LAST_BIT);
    w_div_done     = w_div_last_bit && (r_op_idx == 2'd3);
  end

  // Next-state logic of the ACCUM -> DIV -> COMMIT sequence.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ACCUM: begin
        if (w_accept && !start && in_last) begin
          w_next_state = DIV;
        end else begin
          w_next_state = ACCUM;
        end
      end
      DIV: begin
        if (w_div_done) begin
          w_next_state = COMMIT;
        end else begin
          w_next_state = DIV;
        end
      end
      COMMIT:  w_next_state = ACCUM;
      default: w_next_state = ACCUM;
    endcase
  end

  // State register and registered ready flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ACCUM;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_next_state;
      r_in_ready <= (w_next_state == ACCUM);
    end
  end

  // Per-cluster sums/counts and the sticky overflow flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sum0_d0 <= '0; r_sum0_d1 <= '0; r_sum1_d0 <= '0; r_sum1_d1 <= '0;
      r_cnt0    <= '0; r_cnt1    <= '0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        ACCUM: begin
          if (start) begin
            r_sum0_d0 <= '0; r_sum0_d1 <= '0; r_sum1_d0 <= '0; r_sum1_d1 <= '0;
            r_cnt0    <= '0; r_cnt1    <= '0;
            r_err     <= 1'b0;
          end else if (w_take) begin
            if (in_cluster) begin
              r_sum1_d0 <= r_sum1_d0 + SW'(in_d0);
              r_sum1_d1 <= r_sum1_d1 + SW'(in_d1);
              r_cnt1    <= r_cnt1 + CW'(1'b1);
            end else begin
              r_sum0_d0 <= r_sum0_d0 + SW'(in_d0);
              r_sum0_d1 <= r_sum0_d1 + SW'(in_d1);
              r_cnt0    <= r_cnt0 + CW'(1'b1);
            end
          end else if (w_drop) begin
            r_err <= 1'b1;
          end else begin
            r_err <= r_err;
          end
        end
        COMMIT: begin
          r_sum0_d0 <= '0; r_sum0_d1 <= '0; r_sum1_d0 <= '0; r_sum1_d1 <= '0;
          r_cnt0    <= '0; r_cnt1    <= '0;
        end
        default: begin
          r_err <= r_err;
        end
      endcase
    end
  end

  // Operand selection for the shared divider; sums stay frozen during DIV,
  // so the dividend bits are read straight from the accumulators.
  always_comb begin
    case (r_op_idx)
      2'd0:    begin w_sum_sel = r_sum0_d0; w_cnt_sel = r_cnt0; w_old_sel = r_k0_d0; end
      2'd1:    begin w_sum_sel = r_sum0_d1; w_cnt_sel = r_cnt0; w_old_sel = r_k0_d1; end
      2'd2:    begin w_sum_sel = r_sum1_d0; w_cnt_sel = r_cnt1; w_old_sel = r_k1_d0; end
      default: begin w_sum_sel = r_sum1_d1; w_cnt_sel = r_cnt1; w_old_sel = r_k1_d1; end
    endcase
`ifdef KMEANS_ROUND_EN
    w_dividend = {1'b0, w_sum_sel} + DVW'(w_cnt_sel >> 1);
`else
    w_dividend = w_sum_sel;
`endif
  end

  // One restoring step per cycle, dividend consumed MSB first.
  always_comb begin
    w_dvd_bit   = w_dividend[LAST_BIT - r_bit_cnt];
    w_rem_shift = {r_rem, w_dvd_bit};
    w_qbit      = (w_rem_shift >= {1'b0, w_cnt_sel});
    if (w_qbit) begin
      w_rem_next = CW'(w_rem_shift - {1'b0, w_cnt_sel});
    end else begin
      w_rem_next = w_rem_shift[CW-1:0];
    end
    w_quot_next = {r_quot, w_qbit};
    w_res_cur   = f_to_centroid(w_quot_next, w_cnt_sel, w_old_sel);
  end

  // Divider sequencing: the next operand starts right after the last bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bit_cnt <= '0;
      r_op_idx  <= 2'd0;
      r_rem     <= '0;
      r_quot    <= '0;
    end else if (r_state == DIV) begin
      if (w_div_last_bit) begin
        r_bit_cnt <= '0;
        r_op_idx  <= r_op_idx + 2'd1;
        r_rem     <= '0;
        r_quot    <= '0;
      end else begin
        r_bit_cnt <= r_bit_cnt + BCW'(1'b1);
        r_rem     <= w_rem_next;
        r_quot    <= w_quot_next[DVW-2:0];
      end
    end else begin
      r_bit_cnt <= '0;
      r_op_idx  <= 2'd0;
      r_rem     <= '0;
      r_quot    <= '0;
    end
  end

  // Holds the first three results until the fourth one is ready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_res0 <= '0; r_res1 <= '0; r_res2 <= '0;
    end else if (w_div_last_bit) begin
      case (r_op_idx)
        2'd0:    r_res0 <= w_res_cur;
        2'd1:    r_res1 <= w_res_cur;
        2'd2:    r_res2 <= w_res_cur;
        default: r_res2 <= r_res2;
      endcase
    end else begin
      r_res0 <= r_res0;
    end
  end

  // Centroid commit: all four values update together, visible with done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_k0_d0     <= data_width'(k0_d0_initial);
      r_k0_d1     <= data_width'(k0_d1_initial);
      r_k1_d0     <= data_width'(k1_d0_initial);
      r_k1_d1     <= data_width'(k1_d1_initial);
      r_done      <= 1'b0;
      r_converged <= 1'b0;
    end else if (w_div_done) begin
      r_k0_d0     <= r_res0;
      r_k0_d1     <= r_res1;
      r_k1_d0     <= r_res2;
      r_k1_d1     <= w_res_cur;
      r_done      <= 1'b1;
      r_converged <= (r_res0 == r_k0_d0) && (r_res1 == r_k0_d1) &&
                     (r_res2 == r_k1_d0) && (w_res_cur == r_k1_d1);
    end else begin
      r_done      <= 1'b0;
    end
  end

  assign in_ready  = r_in_ready;
  assign k0_d0     = r_k0_d0;
  assign k0_d1     = r_k0_d1;
  assign k1_d0     = r_k1_d0;
  assign k1_d1     = r_k1_d1;
  assign done      = r_done;
  assign converged = r_converged;
  assign err       = r_err;

endmodule

// File: doc/kmeans_k2n2_centroid_update.md
Name: kmeans_k2n2_centroid_update

Overview:
- Downstream stage of the k=2, n=2 k-means datapath.
- Consumes classified points (d0, d1, cluster id) from the assignment stage and accumulates per-cluster sums and counts over one pass.
- At end of pass, divides sums by counts with a sequential restoring divider and commits the new centroids.
- Centroids feed back to the assignment stage; a convergence flag tells the top-level controller to stop iterating.

Parameters:
data_width, 8, width of each coordinate and centroid component
input_data_qty_bit_width, 8, width of the point-index space; sum width SW = data_width + input_data_qty_bit_width, count width CW = input_data_qty_bit_width + 1
input_data_qty, 256, maximum points accepted per pass
k0_d0_initial, 0, reset value of centroid 0 dim 0
k0_d1_initial, 0, reset value of centroid 0 dim 1
k1_d0_initial, 1, reset value of centroid 1 dim 0
k1_d1_initial, 1, reset value of centroid 1 dim 1

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  pulse: begin new pass, clear accumulators
in_valid  in  1  point present
in_ready  out  1  block can accept a point
in_d0  in  data_width  point dim 0
in_d1  in  data_width  point dim 1
in_cluster  in  1  assigned cluster, 0 or 1
in_last  in  1  qualifies the final point of the pass
k0_d0, k0_d1, k1_d0, k1_d1  out  data_width each  current centroids, registered
done  out  1  one-cycle pulse when new centroids are committed
converged  out  1  new centroids equal previous ones; valid from done, held until next done
err  out  1  sticky: point dropped because count reached input_data_qty; cleared by start

Behaviour:
- Reset (rst=0, async):
  - centroids = *_initial parameters
  - sums, counts, err, done, converged = 0
  - FSM = ACCUM, in_ready = 1
- FSM states: ACCUM, DIV, COMMIT.
- ACCUM:
  - in_ready = 1; accept on in_valid && in_ready.
  - Accepted point adds in_d0/in_d1 to sum[in_cluster][dim]; count[in_cluster] increments.
  - If count0+count1 == input_data_qty already, the point is dropped and err is set.
  - start in ACCUM clears sums and counts (same cycle, start wins over a simultaneous point) and clears err.
  - Accepted point with in_last moves the FSM to DIV; that point is included in the sums.
  - in_last with in_valid=0 is ignored.
- DIV:
  - in_ready = 0; in_valid is ignored and not buffered; start is ignored.
  - Four quotients computed in order: k0_d0, k0_d1, k1_d0, k1_d1.
  - Each quotient takes SW cycles, one restoring bit per cycle; the next operand loads on the final bit cycle of the previous one, with no gap.
  - Count 0 for a cluster: both of its quotients are forced to the previous centroid value (empty cluster keeps its position).
  - Quotient is truncated to data_width (mathematically it always fits).
- COMMIT (1 cycle):
  - Centroid registers load the quotients.
  - converged = all four new values equal the old values.
  - done = 1 for exactly this cycle.
  - Sums and counts are cleared; next state is ACCUM.
- Latency: last point accepted at edge E0 → done high in the cycle after edge E0 + 4·SW. Default: 64 DIV cycles, done at cycle 65 after last.
- Centroid outputs change only at COMMIT (and at reset).
- Reset mid-DIV or mid-COMMIT aborts immediately; no partial centroid update is visible.

Optional Feature:
- Macro: KMEANS_ROUND_EN.
- Defined: the dividend is sum + (count >> 1) → round-half-up mean. The addition uses SW+1 bits internally, and the divider runs SW+1 cycles per operand. Latency becomes 4·(SW+1); the result is clamped to 2^data_width − 1.
- Undefined: truncating division, latency 4·SW, no extra adder.

Test Plan:
- Reset → k0=(0,0), k1=(1,1), in_ready=1, done=0, converged=0, err=0.
- start; points (10,20)→c0, (12,22)→c0, (100,200)→c1, (102,201)→c1 with last → done exactly 65 cycles after last accept; k0=(11,21), k1=(101,200); converged=0. With KMEANS_ROUND_EN: k1=(101,201), done at cycle 69.
- Repeat the identical pass → same centroids, converged=1.
- start; (4,4)→c0, (6,6)→c0 last → k0=(5,5), k1 unchanged; no hang on the zero divisor.
- Hold in_valid=1 throughout DIV → in_ready=0, no accumulation; the next pass's sums start from 0.
- Assert rst low 10 cycles into DIV → outputs immediately return to initial values, in_ready=1, no done pulse.
- With input_data_qty=4: send 5 points → 5th dropped, err=1; next start clears err.
